// File: rtl/wt_cache_pkg.sv
// Shared dcache types and constants for the SHiP re-reference predictor.
// Holds the per-line metadata record, RRPV encodings and cache geometry.
package wt_cache_pkg;

    localparam int unsigned DCACHE_SET_ASSOC    = 4;
    localparam int unsigned DCACHE_NUM_WORDS    = 16;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);

    localparam int unsigned SHIP_SIG_WIDTH = 8;

    typedef struct packed {
        logic                      valid;
        logic                      reuse;
        logic [SHIP_SIG_WIDTH-1:0] sig;
    } ship_meta_t;

    localparam logic [1:0] RRPV_NEAR = 2'd0;
    localparam logic [1:0] RRPV_LONG = 2'd2;
    localparam logic [1:0] RRPV_DIST = 2'd3;

    localparam int unsigned SHCT_INIT = 1;

endpackage

// File: rtl/wt_dcache_ship_shct.sv
// Signature history counter table: saturating counters with merged inc/dec update.
// Define WT_DCACHE_SHIP_BYPASS_EN to forward same-cycle updates to the lookup port.
module wt_dcache_ship_shct
    import wt_cache_pkg::*;
#(
    parameter int unsigned SIG_WIDTH = 8,
    parameter int unsigned CTR_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [SIG_WIDTH-1:0] lookup_sig_i,
    output logic [CTR_WIDTH-1:0] lookup_ctr_o,
    input  logic                 inc_i,
    input  logic [SIG_WIDTH-1:0] inc_sig_i,
    input  logic                 dec_i,
    input  logic [SIG_WIDTH-1:0] dec_sig_i
);

    localparam int unsigned        NUM_ENTRIES = 2 ** SIG_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CMAX      = '1;

    logic [CTR_WIDTH-1:0] ctr_q [NUM_ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_d [NUM_ENTRIES];
    logic                 collide;

    // An increment and a decrement of the same entry cancel out.
    assign collide = inc_i && dec_i && (inc_sig_i == dec_sig_i);

    always_comb begin
        ctr_d = ctr_q;
        if (inc_i && !collide && (ctr_q[inc_sig_i] != CMAX)) begin
            ctr_d[inc_sig_i] = ctr_q[inc_sig_i] + 1'b1;
        end
        if (dec_i && !collide && (ctr_q[dec_sig_i] != '0)) begin
            ctr_d[dec_sig_i] = ctr_q[dec_sig_i] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_WIDTH'(SHCT_INIT);
        end else if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_WIDTH'(SHCT_INIT);
        end else begin
            ctr_q <= ctr_d;
        end
    end

`ifdef WT_DCACHE_SHIP_BYPASS_EN
    assign lookup_ctr_o = ctr_d[lookup_sig_i];
`else
    assign lookup_ctr_o = ctr_q[lookup_sig_i];
`endif

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// SHiP insertion predictor feeding the dcache SRRIP unit; trains from per-line reuse.
// Optional lookup bypass of same-cycle SHCT updates: WT_DCACHE_SHIP_BYPASS_EN.
module wt_dcache_ship_pred
    import wt_cache_pkg::*;
#(
    parameter int unsigned SIG_WIDTH = SHIP_SIG_WIDTH,
    parameter int unsigned CTR_WIDTH = 3,
    parameter int unsigned PC_WIDTH  = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                miss_alloc_i,
    input  logic [PC_WIDTH-1:0]                 miss_pc_i,
    input  logic                                fill_i,
    input  logic [DCACHE_CL_IDX_WIDTH-1:0]      fill_idx_i,
    input  logic [$clog2(DCACHE_SET_ASSOC)-1:0] fill_way_i,
    input  logic                                hit_i,
    input  logic [DCACHE_CL_IDX_WIDTH-1:0]      hit_idx_i,
    input  logic [$clog2(DCACHE_SET_ASSOC)-1:0] hit_way_i,
    output logic [1:0]                          pred_result_o,
    output logic                                pred_valid_o
);

    localparam logic [CTR_WIDTH-1:0] CMAX = '1;

    ship_meta_t           meta_q [DCACHE_NUM_WORDS][DCACHE_SET_ASSOC];
    ship_meta_t           victim_meta;
    ship_meta_t           hit_meta;
    logic [SIG_WIDTH-1:0] miss_sig;
    logic [SIG_WIDTH-1:0] fill_sig;
    logic [CTR_WIDTH-1:0] lookup_ctr;
    logic [1:0]           lookup_rrpv;
    logic                 pred_valid_q;
    logic [SIG_WIDTH-1:0] pred_sig_q;
    logic [1:0]           pred_rrpv_q;
    logic                 hit_on_fill;
    logic                 dec_en;
    logic                 inc_en;
    logic                 unused_pc;

    assign miss_sig  = miss_pc_i[SIG_WIDTH+1:2] ^ miss_pc_i[2*SIG_WIDTH+1:SIG_WIDTH+2];
    assign unused_pc = ^{miss_pc_i[PC_WIDTH-1:2*SIG_WIDTH+2], miss_pc_i[1:0]};

    assign victim_meta = meta_q[fill_idx_i][fill_way_i];
    assign hit_meta    = meta_q[hit_idx_i][hit_way_i];

    // A hit on the line being replaced this cycle belongs to the old line; drop it.
    assign hit_on_fill = fill_i && (fill_idx_i == hit_idx_i) && (fill_way_i == hit_way_i);
    assign dec_en      = fill_i && victim_meta.valid && !victim_meta.reuse;
    assign inc_en      = hit_i && !hit_on_fill && hit_meta.valid && !hit_meta.reuse;
    assign fill_sig    = pred_valid_q ? pred_sig_q : '0;

    wt_dcache_ship_shct #(
        .SIG_WIDTH (SIG_WIDTH),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_shct (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .lookup_sig_i (miss_sig),
        .lookup_ctr_o (lookup_ctr),
        .inc_i        (inc_en),
        .inc_sig_i    (hit_meta.sig),
        .dec_i        (dec_en),
        .dec_sig_i    (victim_meta.sig)
    );

    always_comb begin
        lookup_rrpv = RRPV_LONG;
        if (lookup_ctr == '0)      lookup_rrpv = RRPV_DIST;
        else if (lookup_ctr == CMAX) lookup_rrpv = RRPV_NEAR;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q <= 1'b0;
            pred_sig_q   <= '0;
            pred_rrpv_q  <= RRPV_LONG;
        end else if (flush_i) begin
            pred_valid_q <= 1'b0;
            pred_sig_q   <= '0;
            pred_rrpv_q  <= RRPV_LONG;
        end else if (miss_alloc_i) begin
            pred_valid_q <= 1'b1;
            pred_sig_q   <= miss_sig;
            pred_rrpv_q  <= lookup_rrpv;
        end else if (fill_i) begin
            pred_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < DCACHE_NUM_WORDS; s++)
                for (int w = 0; w < DCACHE_SET_ASSOC; w++) meta_q[s][w] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < DCACHE_NUM_WORDS; s++)
                for (int w = 0; w < DCACHE_SET_ASSOC; w++) meta_q[s][w] <= '0;
        end else begin
            if (inc_en) meta_q[hit_idx_i][hit_way_i].reuse <= 1'b1;
            if (fill_i) begin
                meta_q[fill_idx_i][fill_way_i].valid <= 1'b1;
                meta_q[fill_idx_i][fill_way_i].reuse <= 1'b0;
                meta_q[fill_idx_i][fill_way_i].sig   <= fill_sig;
            end
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_result_o = pred_valid_q ? pred_rrpv_q : RRPV_LONG;

endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// Scoreboard bench for wt_dcache_ship_pred: directed scenarios then random traffic
// against a behavioural model of the predictor rules.
module tb_wt_dcache_ship_pred;
    import wt_cache_pkg::*;

    localparam int SIGW = 8;
    localparam int CMAX = 7;
    localparam int NSIG = 256;
    localparam int NSET = DCACHE_NUM_WORDS;
    localparam int NWAY = DCACHE_SET_ASSOC;
    localparam int IW   = DCACHE_CL_IDX_WIDTH;
    localparam int WW   = $clog2(DCACHE_SET_ASSOC);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          miss_alloc;
    logic [63:0]   miss_pc;
    logic          fill;
    logic [IW-1:0] fill_idx;
    logic [WW-1:0] fill_way;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [WW-1:0] hit_way;
    logic [1:0]    pred_result;
    logic          pred_valid;

    wt_dcache_ship_pred dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .miss_alloc_i  (miss_alloc),
        .miss_pc_i     (miss_pc),
        .fill_i        (fill),
        .fill_idx_i    (fill_idx),
        .fill_way_i    (fill_way),
        .hit_i         (hit),
        .hit_idx_i     (hit_idx),
        .hit_way_i     (hit_way),
        .pred_result_o (pred_result),
        .pred_valid_o  (pred_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int shct_m [NSIG];
    bit mv [NSET][NWAY];
    bit mr [NSET][NWAY];
    int ms [NSET][NWAY];
    bit pv;
    int psig;
    int prr;

    typedef struct { bit v; int rr; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    function automatic int sig_of(input logic [63:0] pc);
        return int'(pc[SIGW+1:2] ^ pc[2*SIGW+1:SIGW+2]);
    endfunction

    function automatic int rrpv_of(input int c);
        if (c == 0)    return 3;
        if (c == CMAX) return 0;
        return 2;
    endfunction

    function automatic logic [63:0] pc_for(input int s);
        return 64'(s) << 2;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_table(input string name);
        int first;
        first = -1;
        for (int i = 0; i < NSIG; i++)
            if (first < 0 && int'(dut.u_shct.ctr_q[i]) != shct_m[i]) first = i;
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s: shct[%0d] got %0d expected %0d", name, first,
                     int'(dut.u_shct.ctr_q[first]), shct_m[first]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSIG; i++) shct_m[i] = 1;
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NWAY; w++) begin
                mv[s][w] = 0; mr[s][w] = 0; ms[s][w] = 0;
            end
        pv = 0; psig = 0; prr = 2;
    endtask

    // Applies one clock of the predictor rules to the model using the driven inputs.
    task automatic model_step();
        int  s, fi, fw, hi, hw, pre, post, lk, dsig, isig;
        bit  dec_en, inc_en, same_line, cancel;
        if (flush) begin
            model_reset();
            return;
        end
        s  = sig_of(miss_pc);
        fi = int'(fill_idx); fw = int'(fill_way);
        hi = int'(hit_idx);  hw = int'(hit_way);
        same_line = fill && hit && fi == hi && fw == hw;
        dec_en = fill && mv[fi][fw] && !mr[fi][fw];
        inc_en = hit && !same_line && mv[hi][hw] && !mr[hi][hw];
        dsig = ms[fi][fw];
        isig = ms[hi][hw];
        cancel = dec_en && inc_en && dsig == isig;
        pre = shct_m[s];
        if (dec_en && !cancel && shct_m[dsig] > 0)    shct_m[dsig] = shct_m[dsig] - 1;
        if (inc_en && !cancel && shct_m[isig] < CMAX) shct_m[isig] = shct_m[isig] + 1;
        post = shct_m[s];
`ifdef WT_DCACHE_SHIP_BYPASS_EN
        lk = post;
`else
        lk = pre;
`endif
        if (inc_en) mr[hi][hw] = 1;
        if (fill) begin
            mv[fi][fw] = 1;
            mr[fi][fw] = 0;
            ms[fi][fw] = pv ? psig : 0;
        end
        if (miss_alloc) begin
            pv = 1; psig = s; prr = rrpv_of(lk);
        end else if (fill) begin
            pv = 0;
        end
    endtask

    task automatic clear_inputs();
        flush = 0; miss_alloc = 0; miss_pc = '0;
        fill = 0; fill_idx = '0; fill_way = '0;
        hit = 0; hit_idx = '0; hit_way = '0;
    endtask

    // Caller drives inputs at posedge+1; the expected output after the edge is queued.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        e.v  = pv;
        e.rr = pv ? prr : 2;
        exp_q.push_back(e);
        #1;
        clear_inputs();
    endtask

    task automatic do_miss(input int s);
        miss_alloc = 1; miss_pc = pc_for(s); cycle();
    endtask

    task automatic do_fill(input int set, input int way);
        fill = 1; fill_idx = IW'(set); fill_way = WW'(way); cycle();
    endtask

    task automatic do_hit(input int set, input int way);
        hit = 1; hit_idx = IW'(set); hit_way = WW'(way); cycle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pred_valid", int'(pred_valid), int'(e.v));
            check("pred_result", int'(pred_result), e.rr);
        end
    end

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1;
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(pred_valid), 0);
        check("reset_result", int'(pred_result), 2);
        check_table("reset_shct");
        rst_n = 1;

        // First prediction: pc 0x1000 -> signature 4, weak counter -> long
        miss_alloc = 1; miss_pc = 64'h1000; cycle();

        // Fill set 5 way 2 with sig 4, hit three times: trains once
        do_fill(5, 2);
        repeat (3) do_hit(5, 2);
        check_table("hit_train_once");
        check("meta_reuse", int'(dut.meta_q[5][2].reuse), int'(mr[5][2]));

        // Dead-line eviction drives the counter to 0 -> distant insertion
        do_miss(20); do_fill(6, 1);
        do_miss(21); do_fill(6, 1);
        do_miss(20);
        check_table("evict_decrement");

        // Six reused lines saturate the counter -> near insertion, stays at max
        for (int k = 0; k < 6; k++) begin
            do_miss(30); do_fill(k, 3); do_hit(k, 3);
        end
        do_miss(30);
        do_fill(7, 3); do_hit(7, 3);
        check_table("saturate_max");

        // Same-cycle dec and inc of one entry cancel; lookup of that entry in parallel
        do_miss(40); do_fill(8, 0);
        do_miss(40); do_fill(9, 0);
        fill = 1; fill_idx = IW'(8); fill_way = '0;
        hit = 1;  hit_idx = IW'(9);  hit_way = '0;
        miss_alloc = 1; miss_pc = pc_for(40);
        cycle();
        check_table("inc_dec_cancel");

        // Lookup colliding with a net decrement: pre vs post value selects the RRPV
        do_miss(50); do_fill(10, 0);
        fill = 1; fill_idx = IW'(10); fill_way = '0;
        miss_alloc = 1; miss_pc = pc_for(50);
        cycle();
        check_table("lookup_collide");

        // Fill and hit on the same line: the hit is dropped
        do_miss(55); do_fill(11, 1);
        fill = 1; fill_idx = IW'(11); fill_way = WW'(1);
        hit = 1;  hit_idx = IW'(11);  hit_way = WW'(1);
        cycle();
        check_table("fill_over_hit");

        // Flush wins over a concurrent miss and hit
        flush = 1; miss_alloc = 1; miss_pc = pc_for(60);
        hit = 1; hit_idx = IW'(9); hit_way = '0;
        cycle();
        check_table("flush_shct");
        check("flush_meta", int'(dut.meta_q[5][2].valid), int'(mv[5][2]));
        do_hit(9, 0);
        check_table("flush_no_train");

        // Asynchronous reset with a prediction pending
        do_miss(3);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("async_rst_valid", int'(pred_valid), 0);
        check("async_rst_result", int'(pred_result), 2);
        model_reset();
        check_table("async_rst_shct");
        @(posedge clk);
        #1 rst_n = 1;

        // Random traffic over a small signature/set space to force collisions
        for (int n = 0; n < 3000; n++) begin
            int s;
            flush      = ($urandom_range(0, 199) == 0);
            miss_alloc = ($urandom_range(0, 9) < 4);
            s          = int'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) miss_pc = {$urandom, $urandom};
            else                           miss_pc = pc_for(s);
            fill     = ($urandom_range(0, 9) < 3);
            fill_idx = IW'($urandom_range(0, 3));
            fill_way = WW'($urandom_range(0, NWAY - 1));
            hit      = ($urandom_range(0, 9) < 5);
            hit_idx  = IW'($urandom_range(0, 3));
            hit_way  = WW'($urandom_range(0, NWAY - 1));
            cycle();
            if (n % 500 == 499) check_table("rand_shct");
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
